// File: rtl/multi_operand_adder_pipe.sv
// multi_operand_adder_pipe: NUM_IN-operand adder, one operand per stage, sticky overflow; define ADDER_SATURATE_EN to clamp overflowed results to all-ones
module multi_operand_adder_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_ovf,
  output logic                    out_valid,
  input  logic                    out_ready
);
  localparam int S = NUM_IN - 1;
  logic [S-1:0] vld_q, vld_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] sum_q [S];
  logic [WIDTH-1:0] sum_d [S];
  logic [NUM_IN*WIDTH-1:0] rest_q [S];
  logic [NUM_IN*WIDTH-1:0] rest_d [S];
  logic adv;
  assign adv = rst && (!vld_q[S-1] || out_ready);
  assign in_ready = adv;
  genvar s;
  for (s = 0; s < S; s++) begin : g_stage
    logic [WIDTH:0] add;
    if (s == 0) begin : g_first
      assign add       = {1'b0, in_data[WIDTH-1:0]} + {1'b0, in_data[2*WIDTH-1:WIDTH]};
      assign vld_d[s]  = in_valid;
      assign ovf_d[s]  = add[WIDTH];
      assign rest_d[s] = in_data >> (2*WIDTH);
    end else begin : g_next
      assign add       = {1'b0, sum_q[s-1]} + {1'b0, rest_q[s-1][WIDTH-1:0]};
      assign vld_d[s]  = vld_q[s-1];
      assign ovf_d[s]  = ovf_q[s-1] | add[WIDTH];
      assign rest_d[s] = rest_q[s-1] >> WIDTH;
    end
    assign sum_d[s] = add[WIDTH-1:0];
  end
  // all stages shift together; a stalled output freezes the whole pipe
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      vld_q  <= '0;
      ovf_q  <= '0;
      sum_q  <= '{default: '0};
      rest_q <= '{default: '0};
    end else if (adv) begin
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
      sum_q  <= sum_d;
      rest_q <= rest_d;
    end
  assign out_valid = vld_q[S-1];
  assign out_ovf   = ovf_q[S-1];
`ifdef ADDER_SATURATE_EN
  assign out_data = out_ovf ? '1 : sum_q[S-1];
`else
  assign out_data = sum_q[S-1];
`endif
endmodule

// File: tb/tb_multi_operand_adder_pipe.sv
// tb_multi_operand_adder_pipe: randomized and directed checks of the adder pipeline against an arithmetic model
module tb_multi_operand_adder_pipe;
  localparam int W = 8;
  localparam int N = 4;
  logic clk = 0;
  logic rst = 0;
  logic [N*W-1:0] in_data = '0;
  logic in_valid = 0, in_ready, out_ovf, out_valid, out_ready = 0;
  logic [W-1:0] out_data;
  logic [7:0] s_in_data = '0;
  logic s_in_valid = 0, s_in_ready, s_out_ovf, s_out_valid, s_out_ready = 0;
  logic [3:0] s_out_data;
  int n_chk = 0;
  int n_fail = 0;
  multi_operand_adder_pipe #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ovf(out_ovf), .out_valid(out_valid), .out_ready(out_ready));
  multi_operand_adder_pipe #(.WIDTH(4), .NUM_IN(2)) dut_s (
    .clk(clk), .rst(rst), .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .out_data(s_out_data), .out_ovf(s_out_ovf), .out_valid(s_out_valid), .out_ready(s_out_ready));
  always #5 clk = ~clk;
  function automatic void model(input logic [31:0] d, input int w, input int n,
                                output logic [31:0] data, output logic ovf);
    longint sum, m;
    sum = 0;
    m = longint'(1) << w;
    for (int k = 0; k < n; k++) sum += longint'((d >> (k*w))) & (m - 1);
    ovf = sum >= m;
    data = 32'(sum % m);
`ifdef ADDER_SATURATE_EN
    if (ovf) data = 32'(m - 1);
`endif
  endfunction
  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    logic [31:0] r;
    r = {d[7:0], c[7:0], b[7:0], a[7:0]};
    return r;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 0;
    in_valid = 1;
    out_ready = 1;
    in_data = $urandom;
    step();
    step();
    n_chk++;
    if (out_valid !== 0 || out_data !== 0 || out_ovf !== 0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%0b data=%0d ovf=%0b expected 0/0/0", out_valid, out_data, out_ovf);
    end
    n_chk++;
    if (in_ready !== 0 || s_in_ready !== 0) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %0b/%0b expected 0/0", in_ready, s_in_ready);
    end
    in_valid = 0;
    rst = 1;
    #1;
  endtask
  task automatic test_basic();
    int n;
    in_data = pack4(10, 20, 30, 40);
    in_valid = 1;
    out_ready = 1;
    #1;
    n_chk++;
    if (in_ready !== 1) begin
      n_fail++;
      $display("FAIL basic_in_ready: got %0b expected 1", in_ready);
    end
    step();
    in_valid = 0;
    n = 1;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    n_chk++;
    if (n !== 3) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d edges expected 3", n);
    end
    n_chk++;
    if (out_valid !== 1 || out_data !== 100 || out_ovf !== 0) begin
      n_fail++;
      $display("FAIL basic_result: got valid=%0b data=%0d ovf=%0b expected 1/100/0", out_valid, out_data, out_ovf);
    end
    step();
    n_chk++;
    if (out_valid !== 0) begin
      n_fail++;
      $display("FAIL basic_one_cycle: got valid=%0b expected 0", out_valid);
    end
  endtask
  task automatic test_overflow();
    logic [31:0] ed;
    logic eo;
    in_data = pack4(200, 100, 0, 0);
    model(in_data, W, N, ed, eo);
    in_valid = 1;
    out_ready = 1;
    step();
    in_valid = 0;
    step();
    step();
`ifdef ADDER_SATURATE_EN
    n_chk++;
    if (ed !== 255) begin
      n_fail++;
      $display("FAIL ovf_model: got %0d expected 255", ed);
    end
`else
    n_chk++;
    if (ed !== 44) begin
      n_fail++;
      $display("FAIL ovf_model: got %0d expected 44", ed);
    end
`endif
    n_chk++;
    if (out_valid !== 1 || out_data !== ed[W-1:0] || out_ovf !== 1) begin
      n_fail++;
      $display("FAIL ovf_result: got valid=%0b data=%0d ovf=%0b expected 1/%0d/1", out_valid, out_data, out_ovf, ed);
    end
    step();
  endtask
  task automatic test_back_to_back();
    int exp_v [3] = '{4, 8, 12};
    out_ready = 1;
    for (int i = 1; i <= 3; i++) begin
      in_data = pack4(i, i, i, i);
      in_valid = 1;
      step();
    end
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (out_valid !== 1 || out_data !== exp_v[i][W-1:0]) begin
        n_fail++;
        $display("FAIL b2b_result%0d: got valid=%0b data=%0d expected 1/%0d", i, out_valid, out_data, exp_v[i]);
      end
      step();
    end
    n_chk++;
    if (out_valid !== 0) begin
      n_fail++;
      $display("FAIL b2b_drain: got valid=%0b expected 0", out_valid);
    end
  endtask
  task automatic test_stall();
    logic [31:0] da, db, ea, eb;
    logic oa, ob;
    int n;
    da = $urandom;
    db = $urandom;
    model(da, W, N, ea, oa);
    model(db, W, N, eb, ob);
    out_ready = 0;
    in_data = da;
    in_valid = 1;
    step();
    in_data = db;
    step();
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    n_chk++;
    if (out_valid !== 1 || in_ready !== 0) begin
      n_fail++;
      $display("FAIL stall_entry: got valid=%0b in_ready=%0b expected 1/0", out_valid, in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      n_chk++;
      if (out_valid !== 1 || out_data !== ea[W-1:0] || out_ovf !== oa || in_ready !== 0) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got valid=%0b data=%0d ovf=%0b rdy=%0b expected 1/%0d/%0b/0",
                 i, out_valid, out_data, out_ovf, in_ready, ea, oa);
      end
    end
    out_ready = 1;
    #1;
    n_chk++;
    if (in_ready !== 1) begin
      n_fail++;
      $display("FAIL stall_release_ready: got %0b expected 1", in_ready);
    end
    step();
    n_chk++;
    if (out_valid !== 1 || out_data !== eb[W-1:0] || out_ovf !== ob) begin
      n_fail++;
      $display("FAIL stall_second: got valid=%0b data=%0d ovf=%0b expected 1/%0d/%0b", out_valid, out_data, out_ovf, eb, ob);
    end
    step();
    n_chk++;
    if (out_valid !== 0) begin
      n_fail++;
      $display("FAIL stall_drain: got valid=%0b expected 0", out_valid);
    end
  endtask
  task automatic test_reset_midflight();
    int n;
    bit stale;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_data = $urandom;
      in_valid = 1;
      step();
    end
    in_valid = 0;
    rst = 0;
    #1;
    n_chk++;
    if (out_valid !== 0 || out_data !== 0 || out_ovf !== 0 || in_ready !== 0) begin
      n_fail++;
      $display("FAIL midreset_async: got valid=%0b data=%0d ovf=%0b rdy=%0b expected 0/0/0/0", out_valid, out_data, out_ovf, in_ready);
    end
    step();
    step();
    rst = 1;
    stale = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (out_valid) stale = 1;
      step();
    end
    n_chk++;
    if (stale) begin
      n_fail++;
      $display("FAIL midreset_stale: got a result after release expected none");
    end
    in_data = pack4(5, 5, 5, 5);
    in_valid = 1;
    step();
    in_valid = 0;
    n = 1;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    n_chk++;
    if (n !== 3 || out_data !== 20 || out_ovf !== 0) begin
      n_fail++;
      $display("FAIL midreset_next: got edges=%0d data=%0d ovf=%0b expected 3/20/0", n, out_data, out_ovf);
    end
    step();
  endtask
  task automatic test_random();
    logic [W:0] q [$];
    logic [W:0] e;
    logic [31:0] ed;
    logic eo;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom % 4) != 0;
      in_data = $urandom;
      out_ready = ($urandom % 4) != 0;
      #1;
      if (out_valid && out_ready) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_extra: got data=%0d expected no result", out_data);
        end else begin
          e = q.pop_front();
          if ({out_ovf, out_data} !== e) begin
            n_fail++;
            $display("FAIL rand_result: got ovf=%0b data=%0d expected ovf=%0b data=%0d", out_ovf, out_data, e[W], e[W-1:0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        model(in_data, W, N, ed, eo);
        q.push_back({eo, ed[W-1:0]});
      end
      step();
    end
    in_valid = 0;
    out_ready = 1;
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      #1;
      if (out_valid) begin
        n_chk++;
        e = q.pop_front();
        if ({out_ovf, out_data} !== e) begin
          n_fail++;
          $display("FAIL rand_drain: got ovf=%0b data=%0d expected ovf=%0b data=%0d", out_ovf, out_data, e[W], e[W-1:0]);
        end
      end
      step();
    end
    n_chk++;
    if (q.size() !== 0) begin
      n_fail++;
      $display("FAIL rand_lost: got %0d results missing expected 0", q.size());
    end
  endtask
  task automatic test_small();
    logic [31:0] ed;
    logic eo;
    s_in_data = {4'd9, 4'd9};
    model({24'd0, s_in_data}, 4, 2, ed, eo);
    s_in_valid = 1;
    s_out_ready = 1;
    #1;
    n_chk++;
    if (s_in_ready !== 1 || s_out_valid !== 0) begin
      n_fail++;
      $display("FAIL small_idle: got rdy=%0b valid=%0b expected 1/0", s_in_ready, s_out_valid);
    end
    step();
    s_in_valid = 0;
    n_chk++;
    if (s_out_valid !== 1 || s_out_data !== ed[3:0] || s_out_ovf !== 1 || eo !== 1) begin
      n_fail++;
      $display("FAIL small_result: got valid=%0b data=%0d ovf=%0b expected 1/%0d/1", s_out_valid, s_out_data, s_out_ovf, ed);
    end
`ifdef ADDER_SATURATE_EN
    n_chk++;
    if (s_out_data !== 15) begin
      n_fail++;
      $display("FAIL small_sat: got %0d expected 15", s_out_data);
    end
`else
    n_chk++;
    if (s_out_data !== 2) begin
      n_fail++;
      $display("FAIL small_wrap: got %0d expected 2", s_out_data);
    end
`endif
    step();
    n_chk++;
    if (s_out_valid !== 0) begin
      n_fail++;
      $display("FAIL small_drain: got valid=%0b expected 0", s_out_valid);
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_random();
    test_small();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_operand_adder_pipe.md
MULTI_OPERAND_ADDER_PIPE -- requirements
Module: multi_operand_adder_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter NUM_IN, default 4: operands summed per transaction (legal range 2..8).
REQ-003 The block SHALL have port clk  input  1: rising-edge clock.
REQ-004 The block SHALL have port rst  input  1: reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_data  input  NUM_IN*WIDTH: packed operands; operand k is bits [k*WIDTH +: WIDTH].
REQ-006 The block SHALL have port in_valid  input  1: in_data holds a transaction.
REQ-007 The block SHALL have port in_ready  output  1: block accepts a transaction this cycle.
REQ-008 The block SHALL have port out_data  output  WIDTH: result of the transaction.
REQ-009 The block SHALL have port out_ovf  output  1: true sum exceeded 2^WIDTH-1.
REQ-010 The block SHALL have port out_valid  output  1: out_data/out_ovf hold a result.
REQ-011 The block SHALL have port out_ready  input  1: downstream consumes the result this cycle.

Function
REQ-012 The block SHALL implement a linear pipeline of NUM_IN-1 register stages: stage 1 holds op0+op1; stage s (s>=2) holds stage s-1 partial sum plus op s; the last stage drives the outputs.
REQ-013 Each stage SHALL register a valid bit, WIDTH-bit partial sum, sticky overflow bit and the not-yet-added operands of its transaction.
REQ-014 A transaction SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-015 in_ready SHALL equal (!out_valid || out_ready), combinationally; in_ready SHALL be 0 while rst is low.
REQ-016 When out_valid=1 and out_ready=0 (stall), every stage SHALL hold its contents, and out_data/out_ovf SHALL remain stable.
REQ-017 When not stalled, every stage SHALL advance one position per edge; empty stages (valid=0) SHALL propagate as bubbles.
REQ-018 A transaction accepted at edge t with no stall SHALL present out_valid=1 after edge t+NUM_IN-2 (latency NUM_IN-1 edges, first result visible in cycle following edge t+NUM_IN-2).
REQ-019 Throughput SHALL be one transaction per cycle with out_ready held 1.
REQ-020 Each addition SHALL be WIDTH+1 bits wide; the stored partial sum SHALL be the low WIDTH bits; carry-out SHALL OR into the stage sticky overflow bit.
REQ-021 out_ovf SHALL be 1 if any addition of that transaction produced a carry-out, else 0.
REQ-022 Simultaneous output consume and input accept SHALL both occur in the same edge without loss.

Reset
REQ-023 Asserting rst low SHALL immediately clear all stage valid bits, partial sums, overflow bits and stored operands to 0, regardless of clk.
REQ-024 Outputs during and after reset SHALL be out_data=0, out_ovf=0, out_valid=0.
REQ-025 Reset mid-operation SHALL discard all in-flight transactions; none SHALL appear at the output after release.
REQ-026 After rst returns high, the first transaction SHALL be acceptable on the first rising edge.

Configuration
REQ-027 With macro ADDER_SATURATE_EN defined, out_data SHALL be forced to all-ones (2^WIDTH-1) whenever out_ovf=1; out_ovf SHALL still report overflow.
REQ-028 Without ADDER_SATURATE_EN, out_data SHALL be the modulo-2^WIDTH sum and no saturation logic SHALL exist.

Verification
REQ-029 Defaults, ops {10,20,30,40}, in_valid 1 cycle, out_ready=1 -> out_data=100, out_ovf=0, out_valid high exactly one cycle, 3 edges after accept.
REQ-030 Defaults, ops {200,100,0,0} -> out_ovf=1; out_data=44 without macro, 255 with ADDER_SATURATE_EN.
REQ-031 Back-to-back transactions {1,1,1,1},{2,2,2,2},{3,3,3,3}, out_ready=1 -> results 4,8,12 on consecutive cycles.
REQ-032 Two transactions in flight, out_ready=0 for 5 cycles -> in_ready=0 once out_valid=1, outputs stable, both results delivered in order when out_ready returns 1.
REQ-033 rst pulled low with 3 transactions in flight -> out_valid=0 immediately; no stale result after release; next transaction {5,5,5,5} yields 20.
REQ-034 NUM_IN=2, WIDTH=4, ops {9,9} -> latency 1 edge, out_data=2 (15 with macro), out_ovf=1.
